// File: rtl/mem_sram_banked.sv
// rtl/mem_sram_banked.sv - banked single-port scratch SRAM shared by fetch and load/store ports
module mem_sram_banked #(
  parameter int NUM_BANKS    = 4,
  parameter int BANK_WORDS   = 1024,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [31:0]           i_rdata,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_funct3,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  d_err
);

  localparam int WW  = $clog2(BANK_WORDS);
  localparam int LNB = $clog2(NUM_BANKS);
  localparam int BW  = (LNB > 0) ? LNB : 1;
  localparam int TOP = 2 + WW + LNB;
  localparam int SCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  // Address decode for both ports
  logic [WW-1:0] i_idx, d_idx;
  logic [BW-1:0] i_bank, d_bank;
  logic          i_oor, d_oor;

  assign i_idx  = i_addr[2 +: WW];
  assign d_idx  = d_addr[2 +: WW];
  assign i_bank = (NUM_BANKS > 1) ? i_addr[2+WW +: BW] : '0;
  assign d_bank = (NUM_BANKS > 1) ? d_addr[2+WW +: BW] : '0;
  assign i_oor  = (i_addr >> TOP) != '0;
  assign d_oor  = (d_addr >> TOP) != '0;

  logic           i_bad, d_bad;
  logic [3:0]     d_be;
  logic [31:0]    d_wrep;
  logic           conflict, fetch_wins;
  logic [SCW-1:0] starve_d, starve_q;

  // Request legality, store byte lanes and replicated store data
  always_comb begin
    logic f3_bad, misalign;
    i_bad = (i_addr[1:0] != 2'b00) || i_oor;
    if (d_we) f3_bad = (d_funct3 > 3'd2);
    else      f3_bad = (d_funct3 == 3'b011) || (d_funct3[2:1] == 2'b11);
    misalign = ((d_funct3[1:0] == 2'b01) && d_addr[0]) ||
               ((d_funct3[1:0] == 2'b10) && (d_addr[1:0] != 2'b00));
    d_bad = f3_bad || misalign || d_oor;
    case (d_funct3[1:0])
      2'b00: begin
        d_be   = 4'b0001 << d_addr[1:0];
        d_wrep = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        d_be   = d_addr[1] ? 4'b1100 : 4'b0011;
        d_wrep = {2{d_wdata[15:0]}};
      end
      default: begin
        d_be   = 4'b1111;
        d_wrep = d_wdata;
      end
    endcase
  end

  // Bank arbitration: data wins conflicts until the fetch port has starved long enough
  always_comb begin
    logic i_ok, d_ok;
    i_ok       = i_req && !i_bad;
    d_ok       = d_req && !d_bad;
    conflict   = i_ok && d_ok && (i_bank == d_bank);
    fetch_wins = (starve_q == SCW'(STARVE_LIMIT));
    i_gnt      = i_req && !(conflict && !fetch_wins);
    d_gnt      = d_req && !(conflict && fetch_wins);
    starve_d   = starve_q;
    if (i_gnt)         starve_d = '0;
    else if (conflict) starve_d = starve_q + 1'b1;
  end

  logic [31:0] bank_rdata [NUM_BANKS];

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [31:0] mem [BANK_WORDS];
    logic [31:0] rdata_q;
    logic        d_use, i_use;

    assign d_use = d_gnt && !d_bad && (d_bank == BW'(g));
    assign i_use = i_gnt && !i_bad && (i_bank == BW'(g));

    // Single-port bank: one masked write or one synchronous read per cycle
    always_ff @(posedge clk) begin
      if (d_use && d_we) begin
        for (int k = 0; k < 4; k++) begin
          if (d_be[k]) mem[d_idx][8*k +: 8] <= d_wrep[8*k +: 8];
        end
      end else if (d_use) begin
        rdata_q <= mem[d_idx];
      end else if (i_use) begin
        rdata_q <= mem[i_idx];
      end
    end

    assign bank_rdata[g] = rdata_q;
  end

  logic          i_rvalid_d, i_rvalid_q, i_err_d, i_err_q;
  logic [BW-1:0] i_bank_d, i_bank_q;
  logic          d_rvalid_d, d_rvalid_q, d_err_d, d_err_q, d_we_d, d_we_q;
  logic [1:0]    d_off_d, d_off_q;
  logic [2:0]    d_f3_d, d_f3_q;
  logic [BW-1:0] d_bank_d, d_bank_q;

  // Response context captured at grant time
  always_comb begin
    i_rvalid_d = i_gnt;
    i_err_d    = i_gnt && i_bad;
    i_bank_d   = i_bank;
    d_rvalid_d = d_gnt;
    d_err_d    = d_gnt && d_bad;
    d_we_d     = d_we;
    d_off_d    = d_addr[1:0];
    d_f3_d     = d_funct3;
    d_bank_d   = d_bank;
  end

  // Response and starvation registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q   <= '0;
      i_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      i_bank_q   <= '0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_we_q     <= 1'b0;
      d_off_q    <= 2'b00;
      d_f3_q     <= 3'b000;
      d_bank_q   <= '0;
    end else begin
      starve_q   <= starve_d;
      i_rvalid_q <= i_rvalid_d;
      i_err_q    <= i_err_d;
      i_bank_q   <= i_bank_d;
      d_rvalid_q <= d_rvalid_d;
      d_err_q    <= d_err_d;
      d_we_q     <= d_we_d;
      d_off_q    <= d_off_d;
      d_f3_q     <= d_f3_d;
      d_bank_q   <= d_bank_d;
    end
  end

  // Read return: load alignment and extension; zero unless a clean read is returning
  always_comb begin
    logic [31:0] lw;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ld;
    lw = bank_rdata[d_bank_q];
    lb = lw[{d_off_q, 3'b000} +: 8];
    lh = d_off_q[1] ? lw[31:16] : lw[15:0];
    case (d_f3_q)
      3'b000:  ld = {{24{lb[7]}}, lb};
      3'b001:  ld = {{16{lh[15]}}, lh};
      3'b010:  ld = lw;
      3'b100:  ld = {24'h0, lb};
      3'b101:  ld = {16'h0, lh};
      default: ld = 32'h0;
    endcase
    i_rvalid = i_rvalid_q;
    i_err    = i_err_q;
    i_rdata  = (i_rvalid_q && !i_err_q) ? bank_rdata[i_bank_q] : 32'h0;
    d_rvalid = d_rvalid_q;
    d_err    = d_err_q;
    d_rdata  = (d_rvalid_q && !d_err_q && !d_we_q) ? ld : 32'h0;
  end

endmodule

// File: tb/tb_mem_sram_banked.sv
// tb/tb_mem_sram_banked.sv - randomized and directed bench with byte-level memory model
module tb_mem_sram_banked;

  localparam int          MEM_SZ    = 16384;
  localparam logic [31:0] MEM_LIMIT = 32'h0000_4000;
  localparam int          LIMIT     = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [2:0]  d_funct3 = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_sram_banked #(.NUM_BANKS(4), .BANK_WORDS(1024), .ADDR_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model: byte-addressed memory ----------------
  logic [7:0] mb [MEM_SZ];
  bit         bv [MEM_SZ];
  int         starve_m = 0;
  bit         ei_v = 0, ei_err = 0, ei_known = 0;
  logic [31:0] ei_data = '0;
  bit         ed_v = 0, ed_err = 0, ed_known = 0;
  logic [31:0] ed_data = '0;

  function automatic int dsz(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit derr(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1;
    if (a >= MEM_LIMIT) return 1;
    return (a % 32'(dsz(f3))) != 0;
  endfunction

  function automatic bit ferr(input logic [31:0] a);
    return (a >= MEM_LIMIT) || (a % 4 != 0);
  endfunction

  function automatic int bank_of(input logic [31:0] a);
    return int'((a / 4096) % 4);
  endfunction

  function automatic logic [31:0] ld_val(input logic [31:0] a, input logic [2:0] f3);
    int n = dsz(f3);
    logic [31:0] v = '0;
    logic [13:0] ix;
    for (int k = 0; k < n; k++) begin
      ix = a[13:0] + 14'(k);
      v = v | (32'(mb[ix]) << (8 * k));
    end
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic bit known(input logic [31:0] a, input int n);
    logic [13:0] ix;
    for (int k = 0; k < n; k++) begin
      ix = a[13:0] + 14'(k);
      if (!bv[ix]) return 0;
    end
    return 1;
  endfunction

  // Scoreboard: compares every cycle against the model, then advances the model
  always @(negedge clk) begin : scoreboard
    bit ie, de, conf, eg_i, eg_d;
    logic [13:0] ix;
    if (!reset_n) begin
      check("reset_flags", {26'h0, i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err}, 32'h0);
      check("reset_i_rdata", i_rdata, 32'h0);
      check("reset_d_rdata", d_rdata, 32'h0);
      ei_v = 0; ed_v = 0; starve_m = 0;
    end else begin
      check("sb_i_rvalid", i_rvalid, ei_v);
      if (ei_v) begin
        check("sb_i_err", i_err, ei_err);
        if (ei_known) check("sb_i_rdata", i_rdata, ei_data);
      end
      check("sb_d_rvalid", d_rvalid, ed_v);
      if (ed_v) begin
        check("sb_d_err", d_err, ed_err);
        if (ed_known) check("sb_d_rdata", d_rdata, ed_data);
      end
      ie   = i_req && ferr(i_addr);
      de   = d_req && derr(d_we, d_funct3, d_addr);
      conf = i_req && !ie && d_req && !de && (bank_of(i_addr) == bank_of(d_addr));
      eg_i = i_req && !(conf && starve_m != LIMIT);
      eg_d = d_req && !(conf && starve_m == LIMIT);
      check("sb_i_gnt", i_gnt, eg_i);
      check("sb_d_gnt", d_gnt, eg_d);
      if (eg_i) starve_m = 0;
      else if (conf && starve_m < LIMIT) starve_m++;
      ei_v = eg_i; ei_err = ie;
      ei_known = !ie && known(i_addr, 4);
      ei_data = ie ? 32'h0 : ld_val(i_addr, 3'b010);
      ed_v = eg_d; ed_err = de;
      if (!eg_d || de || d_we) begin
        ed_known = 1; ed_data = 32'h0;
      end else begin
        ed_known = known(d_addr, dsz(d_funct3));
        ed_data  = ld_val(d_addr, d_funct3);
      end
      if (eg_d && !de && d_we) begin
        for (int k = 0; k < dsz(d_funct3); k++) begin
          ix = d_addr[13:0] + 14'(k);
          mb[ix] = d_wdata[8*k +: 8];
          bv[ix] = 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic data_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
    bit got = 0;
    @(posedge clk); #1;
    d_req = 1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_gnt) begin got = 1; break; end
    end
    check("op_granted", 32'(got), 32'h1);
    @(posedge clk); #1;
    d_req = 0;
    @(negedge clk);
    check("op_rvalid", 32'(d_rvalid), 32'h1);
    rd = d_rdata; er = d_err;
  endtask

  function automatic logic [31:0] win_addr();
    return 32'($urandom_range(0, 3)) * 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
  endfunction

  function automatic logic [31:0] oor_addr();
    return 32'h4000 << $urandom_range(0, 17);
  endfunction

  logic [31:0] rd;
  logic        er;
  bit          ig_s = 0, dg_s = 0;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    check("post_reset_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);

    // Word store then sub-word loads
    data_op(1, 3'b010, 32'h1004, 32'h8899AABB, rd, er);
    check("sw_rdata_zero", rd, 32'h0);
    check("sw_err", 32'(er), 32'h0);
    data_op(0, 3'b000, 32'h1005, 32'h0, rd, er);
    check("lb_1005", rd, 32'hFFFFFFAA);
    data_op(0, 3'b101, 32'h1006, 32'h0, rd, er);
    check("lhu_1006", rd, 32'h00008899);
    data_op(0, 3'b010, 32'h1004, 32'h0, rd, er);
    check("lw_1004", rd, 32'h8899AABB);
    data_op(0, 3'b001, 32'h1006, 32'h0, rd, er);
    check("lh_1006", rd, 32'hFFFF8899);
    data_op(0, 3'b100, 32'h1004, 32'h0, rd, er);
    check("lbu_1004", rd, 32'h000000BB);

    // Byte merge into an existing word
    data_op(1, 3'b010, 32'h2000, 32'hFFFFFFFF, rd, er);
    data_op(1, 3'b000, 32'h2002, 32'h00000011, rd, er);
    data_op(0, 3'b010, 32'h2000, 32'h0, rd, er);
    check("sb_merge", rd, 32'hFF11FFFF);

    // Same-bank conflict and starvation guard
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h1000;
    d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h1400;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("conf_d_gnt", 32'(d_gnt), 32'h1);
      check("conf_i_gnt", 32'(i_gnt), 32'h0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("starve_i_gnt", 32'(i_gnt), 32'h1);
    check("starve_d_gnt", 32'(d_gnt), 32'h0);
    @(posedge clk); #1;
    i_req = 0;
    @(negedge clk);
    check("after_starve_d_gnt", 32'(d_gnt), 32'h1);
    @(posedge clk); #1;
    d_req = 0;

    // Concurrent fetch bank 0 and load bank 2
    data_op(1, 3'b010, 32'h0008, 32'h12345678, rd, er);
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h0008;
    d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h2000;
    @(negedge clk);
    check("conc_gnts", {30'h0, i_gnt, d_gnt}, 32'h3);
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    @(negedge clk);
    check("conc_rvalids", {30'h0, i_rvalid, d_rvalid}, 32'h3);
    check("conc_i_rdata", i_rdata, 32'h12345678);
    check("conc_d_rdata", d_rdata, 32'hFF11FFFF);

    // Error requests
    data_op(0, 3'b001, 32'h0003, 32'h0, rd, er);
    check("lh_misalign_err", 32'(er), 32'h1);
    check("lh_misalign_rdata", rd, 32'h0);
    data_op(1, 3'b010, 32'h0000, 32'hCAFEF00D, rd, er);
    data_op(1, 3'b010, 32'h4000, 32'hDEAD0000, rd, er);
    check("sw_oor_err", 32'(er), 32'h1);
    data_op(0, 3'b010, 32'h4000, 32'h0, rd, er);
    check("lw_oor_err", 32'(er), 32'h1);
    data_op(0, 3'b010, 32'h0000, 32'h0, rd, er);
    check("oor_no_alias", rd, 32'hCAFEF00D);
    data_op(0, 3'b011, 32'h0000, 32'h0, rd, er);
    check("f3_011_err", 32'(er), 32'h1);
    data_op(1, 3'b100, 32'h0000, 32'h0, rd, er);
    check("store_f3_100_err", 32'(er), 32'h1);

    // Error data request never conflicts; misaligned fetch errors
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h1000;
    d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h1401;
    @(negedge clk);
    check("err_no_conflict", {30'h0, i_gnt, d_gnt}, 32'h3);
    @(posedge clk); #1;
    i_addr = 32'h1002; d_req = 0;
    @(negedge clk);
    check("fetch_misalign_gnt", 32'(i_gnt), 32'h1);
    @(posedge clk); #1;
    i_req = 0;
    @(negedge clk);
    check("fetch_misalign_err", 32'(i_err), 32'h1);

    // Reset mid-operation after building up starvation
    @(posedge clk); #1;
    i_req = 1; i_addr = 32'h1000;
    d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h1400;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 0; i_req = 0; d_req = 0;
    @(negedge clk);
    check("midrst_d_rvalid", 32'(d_rvalid), 32'h0);
    check("midrst_d_rdata", d_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    i_req = 1; d_req = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("postrst_i_gnt", 32'(i_gnt), 32'h0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("postrst_starve_i_gnt", 32'(i_gnt), 32'h1);
    @(posedge clk); #1;
    i_req = 0; d_req = 0;

    // Initialise the random window with known words
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 8; w++)
        data_op(1, 3'b010, 32'(b) * 32'h1000 + 32'(w) * 32'd4, $urandom, rd, er);

    // Random traffic on both ports, holding each request until granted
    for (int c = 0; c < 1500; c++) begin
      int r;
      @(posedge clk); #1;
      if (!i_req || ig_s) begin
        r = $urandom_range(0, 9);
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = (r == 0) ? oor_addr() : win_addr() + ((r == 1) ? 32'($urandom_range(1, 3)) : 32'h0);
      end
      if (!d_req || dg_s) begin
        r = $urandom_range(0, 9);
        d_req    = ($urandom_range(0, 3) != 0);
        d_we     = 1'($urandom_range(0, 1));
        d_funct3 = 3'($urandom_range(0, 7));
        d_wdata  = $urandom;
        if (r == 0) d_addr = oor_addr();
        else begin
          d_addr = win_addr();
          if (r < 3 || d_funct3[1:0] == 2'b00) d_addr = d_addr + 32'($urandom_range(0, 3));
          else if (d_funct3[1:0] == 2'b01)     d_addr = d_addr + 32'($urandom_range(0, 1)) * 32'd2;
        end
      end
      @(negedge clk);
      ig_s = i_gnt; dg_s = d_gnt;
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
